// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: redirect input, icache request/response and decode-side queue head.
interface fetch_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Redirect from branch/trap/JSR resolution
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;

  // Icache request/response
  logic [WIDTH-1:0] icache_address;
  logic             icache_read;
  logic [WIDTH-1:0] icache_rdata;
  logic             icache_resp;

  // Decode side
  logic             deq_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_ir;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_new_pc;
  logic [CNT_W-1:0] count;

  // Fetch stage side
  modport slave (
    input  redirect, redirect_pc, icache_rdata, icache_resp, deq_ready,
    output icache_address, icache_read, out_valid, out_ir, out_pc, out_new_pc, count
  );

  // Environment side (icache, decode, redirect source)
  modport master (
    output redirect, redirect_pc, icache_rdata, icache_resp, deq_ready,
    input  icache_address, icache_read, out_valid, out_ir, out_pc, out_new_pc, count
  );

endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, keeps one icache read outstanding and
// queues returned words with their PC for decode; a redirect flushes everything in one cycle.
module fetch_buffer #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WIDTH-1:0]  PC_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(2);

  typedef struct packed {
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [WIDTH-1:0] pc_q,    pc_d;
  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   read_c;
  logic   enq_c;
  logic   deq_c;
  logic   valid_c;
  entry_t head_c;

  // Request whenever there is room; while waiting count can only fall, so the request holds
  assign valid_c = (count_q != '0);
  assign read_c  = !reset && !bus.redirect && (count_q != CNT_FULL);
  assign enq_c   = read_c && bus.icache_resp;
  assign deq_c   = valid_c && bus.deq_ready;

  // Next-state for PC, pointers and occupancy; redirect flushes and discards same-cycle traffic
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_c) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + INSN_BYTES;
      end
      if (deq_c) begin
        head_d = head_q + PTR_W'(1);
      end
      if (enq_c && !deq_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (!enq_c && deq_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage: returned word tagged with the address it was fetched from
  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem_q[tail_q] <= '{ir: bus.icache_rdata, pc: pc_q};
    end
  end

  // Head entry presented to decode, zeroed when the queue is empty
  always_comb begin
    head_c = mem_q[head_q];
    if (!valid_c) begin
      head_c = '0;
    end
  end

  assign bus.icache_address = pc_q;
  assign bus.icache_read    = read_c;
  assign bus.out_valid      = valid_c;
  assign bus.out_ir         = head_c.ir;
  assign bus.out_pc         = head_c.pc;
  assign bus.out_new_pc     = valid_c ? (head_c.pc + INSN_BYTES) : '0;
  assign bus.count          = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: the driver keeps a queue model of the fetch stage,
// the monitor pops expected entries whenever decode takes the head.
module tb_fetch_buffer;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] PC_RESET = 16'h0000;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  int tests = 0;
  int fails = 0;

  ent_t        sbq[$];
  logic [15:0] m_pc;

  fetch_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_buffer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PC_RESET(PC_RESET)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check state, then advance the model at the edge
  task automatic cycle(input logic rst, input logic redir, input logic [15:0] rpc,
                       input logic resp, input logic [15:0] rdata, input logic dready);
    logic exp_read;
    logic enq;
    @(negedge clk);
    reset           = rst;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.icache_resp = resp;
    bus.icache_rdata = rdata;
    bus.deq_ready   = dready;
    exp_read = !rst && !redir && (sbq.size() != DEPTH);
    enq      = exp_read && resp;
    #1;
    chk("icache_read", 32'(bus.icache_read), 32'(exp_read));
    chk("icache_address", 32'(bus.icache_address), 32'(m_pc));
    chk("count", 32'(bus.count), 32'(sbq.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(sbq.size() != 0));
    if (sbq.size() == 0) begin
      chk("idle_out_ir", 32'(bus.out_ir), 32'h0);
      chk("idle_out_pc", 32'(bus.out_pc), 32'h0);
      chk("idle_out_new_pc", 32'(bus.out_new_pc), 32'h0);
    end
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      m_pc = PC_RESET;
    end else if (redir) begin
      sbq.delete();
      m_pc = rpc;
    end else if (enq) begin
      sbq.push_back('{ir: rdata, pc: m_pc});
      m_pc = m_pc + 16'd2;
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry
  initial begin
    ent_t        e;
    logic [15:0] npc;
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid === 1'b1 && bus.deq_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL deq_empty: got out_valid 1 expected no entry at %0t", $time);
        end else begin
          e   = sbq.pop_front();
          npc = e.pc + 16'd2;
          chk("deq_out_ir", 32'(bus.out_ir), 32'(e.ir));
          chk("deq_out_pc", 32'(bus.out_pc), 32'(e.pc));
          chk("deq_out_new_pc", 32'(bus.out_new_pc), 32'(npc));
        end
      end
    end
  end

  initial begin
    logic        r_rst, r_redir, r_resp, r_deq;
    logic [15:0] r_rpc, r_data;
    int          r;

    reset            = 1'b1;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.icache_resp  = 1'b0;
    bus.icache_rdata = '0;
    bus.deq_ready    = 1'b0;
    m_pc             = PC_RESET;

    // Streaming: resp and deq every cycle, one entry per cycle
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 16'h1111, 1);
    repeat (10) begin
      cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 1);
      #1 chk("stream_count_le1", 32'(bus.count <= 3'd1), 32'd1);
    end

    // Fill to full, hold address, then single-cycle drain and refill
    cycle(1, 0, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 0);
    #1;
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_hold_addr", 32'(bus.icache_address), 32'h0008);
    cycle(0, 0, 0, 1, 16'h7777, 0);
    #1 chk("full_resp_ignored", 32'(bus.count), 32'd4);
    cycle(0, 0, 0, 1, 16'h7777, 1);
    #1 chk("full_deq_count", 32'(bus.count), 32'd3);
    cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 1);
    #1 chk("enq_deq_count", 32'(bus.count), 32'd3);
    cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 0);
    #1 chk("refill_count", 32'(bus.count), 32'd4);

    // Redirect with simultaneous resp and deq at count 2
    cycle(1, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 0);
    #1 chk("pre_redirect_count", 32'(bus.count), 32'd2);
    cycle(0, 1, 16'h3000, 1, 16'hBEEF, 1);
    #1;
    chk("redirect_count", 32'(bus.count), 32'd0);
    chk("redirect_valid", 32'(bus.out_valid), 32'd0);
    chk("redirect_addr", 32'(bus.icache_address), 32'h3000);
    cycle(0, 0, 0, 1, 16'h1234, 0);
    #1 chk("redirect_first_pc", 32'(bus.out_pc), 32'h3000);
    cycle(0, 0, 0, 0, 0, 1);

    // Address wrap at the top of the space
    cycle(0, 1, 16'hFFFE, 0, 0, 0);
    cycle(0, 0, 0, 1, 16'h5A5A, 0);
    #1;
    chk("wrap_out_pc", 32'(bus.out_pc), 32'hFFFE);
    chk("wrap_new_pc", 32'(bus.out_new_pc), 32'h0000);
    chk("wrap_next_addr", 32'(bus.icache_address), 32'h0000);
    cycle(0, 0, 0, 0, 0, 1);

    // Reset while a request is outstanding with three entries queued
    cycle(1, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, m_pc ^ 16'hA5A5, 0);
    cycle(0, 0, 0, 0, 0, 0);
    #1 chk("pre_reset_count", 32'(bus.count), 32'd3);
    cycle(1, 0, 0, 1, 16'hDEAD, 1);
    #1;
    chk("midreset_count", 32'(bus.count), 32'd0);
    chk("midreset_addr", 32'(bus.icache_address), 32'(PC_RESET));
    cycle(0, 0, 0, 0, 0, 0);

    // Randomised traffic
    repeat (3000) begin
      r       = int'($urandom_range(0, 99));
      r_rst   = (r < 2);
      r_redir = (r >= 2) && (r < 8);
      r_rpc   = 16'($urandom);
      r_resp  = ($urandom_range(0, 99) < 65);
      r_deq   = ($urandom_range(0, 99) < 55);
      r_data  = 16'($urandom);
      cycle(r_rst, r_redir, r_rpc, r_resp, r_data, r_deq);
    end

    // Drain
    repeat (8) cycle(0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
